// File: rtl/mult_cal.sv
// Unsigned sequential shift-and-add multiplier (M_W x Q_W -> M_W+Q_W) with start/done handshake.
// Define MULT_CAL_FAST_EN for a single-cycle combinational product with the same handshake.
module mult_cal #(
    parameter  int M_W = 2,
    parameter  int Q_W = 3,
    localparam int P_W = M_W + Q_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [M_W-1:0] m,
    input  logic [Q_W-1:0] q,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] p
);

    logic [P_W-1:0] p_q;
    logic           done_q;
    logic           busy_q;

`ifdef MULT_CAL_FAST_EN

    typedef enum logic {IDLE, DONE} state_t;
    state_t state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    p_q     <= P_W'(m) * P_W'(q);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`else

    localparam int CW = (Q_W > 1) ? $clog2(Q_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state_q;
    logic [M_W-1:0] m_q;
    logic [Q_W-1:0] q_q;
    logic [P_W-1:0] acc_q;
    logic [P_W-1:0] acc_d;
    logic [CW-1:0]  cnt_q;

    // Partial product for bit cnt_q; P_W is wide enough that the sum never wraps.
    always_comb begin
        acc_d = acc_q;
        if (q_q[cnt_q])
            acc_d = acc_q + (P_W'(m_q) << cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    m_q     <= m;
                    q_q     <= q;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == CW'(Q_W - 1)) begin
                        p_q     <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`endif

    assign p    = p_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mult_cal.sv
// Randomized self-checking bench for mult_cal; reference product is plain m*q.
module tb_mult_cal;

    localparam int M_W = 2;
    localparam int Q_W = 3;
    localparam int P_W = M_W + Q_W;
`ifdef MULT_CAL_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = Q_W + 1;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [M_W-1:0] m;
    logic [Q_W-1:0] q;
    logic           busy;
    logic           done;
    logic [P_W-1:0] p;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    mult_cal #(.M_W(M_W), .Q_W(Q_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m(m), .q(q),
        .busy(busy), .done(done), .p(p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One start pulse; edges are counted from the accepting edge (edge 1).
    task automatic run_op(input int mv, input int qv, input string tag);
        int  n;
        bit  seen;
        @(negedge clk);
        m = M_W'(mv); q = Q_W'(qv); start = 1'b1;
        n = 0; seen = 0;
        while (n < 20 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                m = M_W'($urandom);
                q = Q_W'($urandom);
                chk({tag, "_busy"}, int'(busy), 1);
            end
            if (done) seen = 1;
        end
        if (seen) n_done++;
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_p"}, int'(p), mv * qv);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, int'(done), 0);
        chk({tag, "_busy_drop"}, int'(busy), 0);
        chk({tag, "_p_hold"}, int'(p), mv * qv);
    endtask

    initial begin
        int cnt;
        int last;
        int periods;
        rst_n = 1'b0; start = 1'b0; m = '0; q = '0;
        #12;
        chk("rst_p", int'(p), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk); rst_n = 1'b1;

        run_op(2, 5, "single");

        n_done = 0;
        for (int mi = 0; mi < (1 << M_W); mi++)
            for (int qi = 0; qi < (1 << Q_W); qi++)
                run_op(mi, qi, "exh");
        chk("exh_count", n_done, (1 << M_W) * (1 << Q_W));

        for (int k = 0; k < 10; k++) begin
            int mv, qv, gap;
            mv  = int'($urandom_range((1 << M_W) - 1));
            qv  = int'($urandom_range((1 << Q_W) - 1));
            gap = int'($urandom_range(3));
            repeat (gap) @(posedge clk);
            run_op(mv, qv, "rand");
        end

        // Start during busy must be ignored and operands isolated.
        @(negedge clk); m = 2'd3; q = 3'd5; start = 1'b1;
        @(negedge clk); m = 2'd1; q = 3'd1; start = 1'b1;
        @(negedge clk); start = 1'b0; m = 2'd2; q = 3'd6;
        cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("ign_count", cnt, 1);
        chk("ign_p", int'(p), 15);

        // Back-to-back with start held high.
        @(negedge clk); m = 2'd3; q = 3'd3; start = 1'b1;
        last = -1; periods = 0;
        for (int e = 0; e < 40 && periods < 3; e++) begin
            @(posedge clk); #1;
            if (done) begin
                chk("b2b_p", int'(p), 9);
                if (last >= 0) begin
                    chk("b2b_period", e - last, LAT + 1);
                    periods++;
                end
                last = e;
            end else if (last >= 0) begin
                chk("b2b_p_stable", int'(p), 9);
            end
        end
        chk("b2b_periods", periods, 3);
        @(negedge clk); start = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1 chk("b2b_idle", int'(busy), 0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk); m = 2'd3; q = 3'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_p", int'(p), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) cnt++;
        end
        chk("arst_quiet", cnt, 0);

        run_op(3, 6, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_cal.md
Name: mult_cal

Overview:
- Unsigned sequential shift-and-add multiplier: M_W-bit multiplicand m times Q_W-bit multiplier q gives a (M_W+Q_W)-bit product p.
- Default is 2-bit × 3-bit → 5-bit product.
- Used as a small arithmetic leaf block with a start/done handshake, one clock domain.

Parameters:
- M_W, 2, width of multiplicand m (≥1)
- Q_W, 3, width of multiplier q (≥1); also the iteration count
- P_W, M_W+Q_W, product width; derived, must not be overridden

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only while idle
- m  in  M_W  unsigned multiplicand, captured on accepted start
- q  in  Q_W  unsigned multiplier, captured on accepted start
- busy  out  1  high while a multiplication is in progress (RUN or DONE state)
- done  out  1  one-cycle pulse: p holds the new product
- p  out  P_W  registered product; holds its value until the next done

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE; p=0; done=0; busy=0.
  - Internal accumulator, counter and operand registers cleared.
  - Any in-flight operation is discarded.
- State IDLE:
  - busy=0.
  - On a clk edge with start=1: capture m and q into internal registers, clear accumulator, counter=0, go to RUN.
- State RUN, repeated for counter i = 0 .. Q_W-1, one per cycle:
  - If captured q[i]=1, accumulator += zero-extended captured m shifted left by i.
  - Arithmetic is P_W bits wide; the maximum product fits, so no overflow is possible.
  - When i reaches Q_W-1, go to DONE on the next edge.
- State DONE (one cycle):
  - p is loaded with the accumulator on the edge entering DONE.
  - done=1 for exactly this cycle; busy=1.
  - Next edge returns to IDLE.
- Latency: start accepted at edge k → done high and p valid after edge k+Q_W+1 (4 edges for defaults).
- start while busy=1 is ignored; it is not queued.
- start held high continuously: the next operation is accepted on the first IDLE edge after DONE. Back-to-back throughput is one result per Q_W+2 cycles.
- m/q changes after capture do not affect the operation in progress.
- Zero operands still take full latency; p=0.
- p, done and busy are all driven from registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro MULT_CAL_FAST_EN.
- Defined:
  - Product is computed combinationally from m and q and registered into p on the accepted-start edge.
  - The FSM goes IDLE→DONE directly: done is high the cycle after the start edge (latency 1), busy=1 only during that DONE cycle.
  - The RUN state and counter are removed.
- Undefined: the iterative behaviour above.
- In both builds, reset and handshake rules and the final p value are identical.

Test Plan:
- Reset: assert rst_n=0 mid-RUN with m=3, q=7 → p=0, done=0, busy=0 immediately (asynchronous). After release, the block is idle and no done pulse appears.
- Single product: m=2, q=5, start pulsed → done high exactly Q_W+1=4 edges later with p=10; busy high from the edge after start through the DONE cycle.
- Exhaustive: for every m in 0..3, q in 0..7, one start per pair → each done shows p=m×q (e.g. m=1,q=6→6; m=3,q=7→21; m=0,q=7→0); the full sweep gives 32 done pulses.
- Ignored start and operand isolation: start m=3,q=5; during RUN pulse start with m=1,q=1 and change inputs → only one done, with p=15.
- Back-to-back: start held high with m=3,q=3 → done pulses every 5 cycles, p=9 each time, p stable between pulses.
- Fast build with MULT_CAL_FAST_EN defined: m=3, q=6 → done and p=18 one cycle after the start edge.
